axi_lite_slave_regs: RTL and testbench

//  AXI4-Lite responder (slave) holding a small bank of 32-bit read/write registers.
//  It is the target side for the AXI4-Lite master blocks.

---
 rtl/axi_lite_slave_regs.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
//
// AXI4-Lite responder holding NUM_REGS 32-bit read/write registers mapped at
// BASE_ADDR. Every write is answered with a B response, every read with an
// R response. Addresses outside the window get SLVERR and touch nothing.
//
// Ports
//   ACLK, ARESETN                 clock (rising edge) and async active-low reset
//   AWADDR/AWVALID/AWREADY        write address channel
//   WDATA/WSTRB/WVALID/WREADY     write data channel (WSTRB[i] -> WDATA[8i+7:8i])
//   BRESP/BVALID/BREADY           write response channel (00 OKAY, 10 SLVERR)
//   ARADDR/ARVALID/ARREADY        read address channel
//   RDATA/RRESP/RVALID/RREADY     read data channel (00 OKAY, 10 SLVERR)
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module axi_lite_slave_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h0011_0000,
  parameter int          NUM_REGS  = 4,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
  typedef enum logic [0:0] { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_e;

  // Unsigned offset compare also rejects addresses below BASE_ADDR (they wrap high).
  function automatic logic in_window(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (off < WIN_BYTES);
  endfunction

  // Word index inside the window; the two byte-offset bits are dropped.
  function automatic logic [IDX_W-1:0] reg_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  // Register bank
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  // Write path state
  w_state_e    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  // Read path state
  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [IDX_W-1:0] w_idx_s;
  logic [IDX_W-1:0] r_idx_s;

  assign w_idx_s = reg_index(awaddr_q);
  assign r_idx_s = reg_index(ARADDR);

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  // Write FSM: capture AW and W independently, commit once both are held, then hold B.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    case (w_state_q)
      W_IDLE: begin
        if (AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = AWADDR;
          awready_d = 1'b0;
        end else begin
          aw_held_d = aw_held_q;
        end

        if (WVALID && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
          wready_d = 1'b0;
        end else begin
          w_held_d = w_held_q;
        end

        // Both halves were captured on earlier edges: commit on this one.
        if (aw_held_q && w_held_q) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          if (in_window(awaddr_q)) begin
            bresp_d = RESP_OKAY;
            for (int b = 0; b < 4; b++) begin
              if (wstrb_q[b]) begin
                regs_d[w_idx_s][8*b +: 8] = wdata_q[8*b +: 8];
              end else begin
                regs_d[w_idx_s][8*b +: 8] = regs_q[w_idx_s][8*b +: 8];
              end
            end
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end else begin
          w_state_d = W_IDLE;
        end
      end

      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end else begin
          w_state_d = W_RESP;
        end
      end

      default: begin
        w_state_d = W_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Read FSM: snapshot the register on the AR edge, hold R until accepted.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          // regs_q is the pre-commit value, so a same-edge write is not visible.
          if (in_window(ARADDR)) begin
            rdata_d = regs_q[r_idx_s];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = 32'h0000_0000;
            rresp_d = RESP_SLVERR;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end

      R_DATA: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end else begin
          r_state_d = R_DATA;
        end
      end

      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // Write-path and register-bank flops.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read-path flops.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0000_0000;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regs
//
// Directed bench for axi_lite_slave_regs (BASE_ADDR 0x0011_0000, 4 registers,
// reset value 0). Inputs change and outputs are sampled on the falling clock
// edge; the DUT acts on the rising edge in between.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int checks = 0;
  int errors = 0;

  axi_lite_slave_regs #(
    .BASE_ADDR(32'h0011_0000),
    .NUM_REGS (4),
    .RESET_VAL(32'h0000_0000)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .AWADDR (AWADDR),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY)
  );

  // 100 MHz clock
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AW and W presented together; BVALID expected one cycle after the handshake.
  task automatic write_same(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input string tag);
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    BREADY = 1'b0;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk({tag, ".awready_low"}, 32'(AWREADY), 32'd0);
    chk({tag, ".wready_low"},  32'(WREADY),  32'd0);
    chk({tag, ".bvalid_not_yet"}, 32'(BVALID), 32'd0);
    @(negedge ACLK);
    chk({tag, ".bvalid"}, 32'(BVALID), 32'd1);
    chk({tag, ".bresp"},  32'(BRESP),  32'(exp_resp));
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk({tag, ".bvalid_clr"}, 32'(BVALID),  32'd0);
    chk({tag, ".awready_up"}, 32'(AWREADY), 32'd1);
    chk({tag, ".wready_up"},  32'(WREADY),  32'd1);
  endtask

  // Single read; RVALID expected one cycle after the AR handshake.
  task automatic read_chk(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk({tag, ".rvalid"},  32'(RVALID),  32'd1);
    chk({tag, ".rdata"},   RDATA,        exp_data);
    chk({tag, ".rresp"},   32'(RRESP),   32'(exp_resp));
    chk({tag, ".arready_low"}, 32'(ARREADY), 32'd0);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk({tag, ".rvalid_clr"}, 32'(RVALID),  32'd0);
    chk({tag, ".arready_up"}, 32'(ARREADY), 32'd1);
  endtask

  initial begin
    ARESETN = 1'b0;
    AWADDR = 32'h0; AWVALID = 1'b0;
    WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0;
    BREADY = 1'b0;
    ARADDR = 32'h0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state
    @(negedge ACLK);
    @(negedge ACLK);
    chk("rst.awready", 32'(AWREADY), 32'd1);
    chk("rst.wready",  32'(WREADY),  32'd1);
    chk("rst.arready", 32'(ARREADY), 32'd1);
    chk("rst.bvalid",  32'(BVALID),  32'd0);
    chk("rst.rvalid",  32'(RVALID),  32'd0);
    chk("rst.rdata",   RDATA,        32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // 1. Same-cycle AW+W, then read back
    write_same(32'h0011_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, "t1.wr");
    read_chk(32'h0011_0004, 32'hDEAD_BEEF, 2'b00, "t1.rd");
    // addr[1:0] is ignored by the decoder
    read_chk(32'h0011_0007, 32'hDEAD_BEEF, 2'b00, "t1.rd_unaligned");

    // 2. Partial strobe
    write_same(32'h0011_0000, 32'h1122_3344, 4'hF, 2'b00, "t2.wr_full");
    write_same(32'h0011_0000, 32'hAABB_CCDD, 4'b0011, 2'b00, "t2.wr_part");
    read_chk(32'h0011_0000, 32'h1122_CCDD, 2'b00, "t2.rd");
    // zero strobe: OKAY, no change
    write_same(32'h0011_0000, 32'hFFFF_FFFF, 4'b0000, 2'b00, "t2.wr_nostrb");
    read_chk(32'h0011_0000, 32'h1122_CCDD, 2'b00, "t2.rd_nostrb");

    // 3. W handshakes three cycles before AW
    WDATA = 32'h0BAD_F00D; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("t3.wready_wait1", 32'(WREADY), 32'd0);
    chk("t3.awready_wait1", 32'(AWREADY), 32'd1);
    @(negedge ACLK);
    chk("t3.wready_wait2", 32'(WREADY), 32'd0);
    chk("t3.bvalid_wait2", 32'(BVALID), 32'd0);
    @(negedge ACLK);
    chk("t3.wready_wait3", 32'(WREADY), 32'd0);
    AWADDR = 32'h0011_0008; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("t3.bvalid_not_yet", 32'(BVALID), 32'd0);
    @(negedge ACLK);
    chk("t3.bvalid", 32'(BVALID), 32'd1);
    chk("t3.bresp",  32'(BRESP),  32'd0);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("t3.bvalid_clr", 32'(BVALID), 32'd0);
    read_chk(32'h0011_0008, 32'h0BAD_F00D, 2'b00, "t3.rd");

    // 4. Out of range (just past the window, and just below it)
    write_same(32'h0011_0010, 32'hCAFE_CAFE, 4'hF, 2'b10, "t4.wr_oor");
    read_chk(32'h0011_0010, 32'h0000_0000, 2'b10, "t4.rd_oor");
    read_chk(32'h0010_FFFC, 32'h0000_0000, 2'b10, "t4.rd_below");
    read_chk(32'h0011_0000, 32'h1122_CCDD, 2'b00, "t4.reg0_same");
    read_chk(32'h0011_000C, 32'h0000_0000, 2'b00, "t4.reg3_same");

    // Same-edge write commit and AR to reg3: read sees the old value
    AWADDR = 32'h0011_000C; AWVALID = 1'b1;
    WDATA = 32'h55AA_55AA; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h0011_000C; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("col.bvalid", 32'(BVALID), 32'd1);
    chk("col.rvalid", 32'(RVALID), 32'd1);
    chk("col.rdata_old", RDATA, 32'h0000_0000);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    read_chk(32'h0011_000C, 32'h55AA_55AA, 2'b00, "col.rd_new");

    // 5. Backpressure on B, then on R
    AWADDR = 32'h0011_000C; AWVALID = 1'b1;
    WDATA = 32'h1234_5678; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t5.bvalid_hold",  32'(BVALID),  32'd1);
      chk("t5.bresp_hold",   32'(BRESP),   32'd0);
      chk("t5.awready_low",  32'(AWREADY), 32'd0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("t5.bvalid_clr", 32'(BVALID),  32'd0);
    chk("t5.awready_up", 32'(AWREADY), 32'd1);

    ARADDR = 32'h0011_000C; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge ACLK);
    ARVALID = 1'b0;
    ARADDR = 32'h0011_0004;
    for (int i = 0; i < 5; i++) begin
      chk("t5.rvalid_hold",  32'(RVALID),  32'd1);
      chk("t5.rdata_hold",   RDATA,        32'h1234_5678);
      chk("t5.rresp_hold",   32'(RRESP),   32'd0);
      chk("t5.arready_low",  32'(ARREADY), 32'd0);
      @(negedge ACLK);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("t5.rvalid_clr", 32'(RVALID), 32'd0);

    // 6. Reset after AW accepted, before W
    AWADDR = 32'h0011_0004; AWVALID = 1'b1;
    ARADDR = 32'h0011_0000; ARVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; ARVALID = 1'b0;
    chk("t6.awready_low", 32'(AWREADY), 32'd0);
    chk("t6.rvalid_pre",  32'(RVALID),  32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("t6.awready_rst", 32'(AWREADY), 32'd1);
    chk("t6.wready_rst",  32'(WREADY),  32'd1);
    chk("t6.arready_rst", 32'(ARREADY), 32'd1);
    chk("t6.rvalid_rst",  32'(RVALID),  32'd0);
    chk("t6.rdata_rst",   RDATA,        32'h0);
    chk("t6.bvalid_rst",  32'(BVALID),  32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    read_chk(32'h0011_0004, 32'h0000_0000, 2'b00, "t6.rd_reg1");
    read_chk(32'h0011_0000, 32'h0000_0000, 2'b00, "t6.rd_reg0");

    // A lone W after reset must not complete the dropped AW
    WDATA = 32'hFFFF_0000; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("t6.no_bvalid", 32'(BVALID), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
